// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory boot loader.
// Optional checksum trailer is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-lane counter and little-endian word assembler; word_valid_c fires
// combinationally on the transfer that completes a word.
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);
  localparam int unsigned ACC_W  = (BYTES_PER_WORD - 1) * 8;

  logic [LANE_W-1:0] lane;
  logic [ACC_W-1:0]  acc;

  assign word_valid_c = en & (lane == LANE_W'(BYTES_PER_WORD - 1));
  assign word_c       = {byte_in, acc};

  // Earlier bytes shift down so the newest lands in the top lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      acc  <= '0;
    end else if (clr) begin
      lane <= '0;
      acc  <= '0;
    end else if (en) begin
      lane <= lane + LANE_W'(1);
      acc  <= {byte_in, acc[ACC_W-1:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed LE byte stream to imem.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum of data bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned LEN_W     = LEN_BYTES * 8;
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t LAST_STATE = CHK;
`else
  localparam loader_state_t LAST_STATE = DONE;
`endif

  loader_state_t state, state_n;
  logic [7:0]      len_lo;
  logic [LEN_W-1:0] len;
  logic [TO_W-1:0] to_cnt;

  logic             rx_state_c, xfer_c, start_c, asm_en_c;
  logic             word_valid_c, last_word_c, timeout_c, rx_state_n_c;
  logic [31:0]      word_c;
  logic [LEN_W-1:0] len_rx_c;

  assign rx_state_c   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHK);
  assign rx_state_n_c = (state_n == LEN_LO) || (state_n == LEN_HI) || (state_n == DATA) || (state_n == CHK);
  assign xfer_c       = rx_valid & rx_ready;
  assign start_c      = start & ((state == IDLE) || (state == DONE) || (state == ERR));
  assign asm_en_c     = xfer_c & (state == DATA);
  assign len_rx_c     = LEN_W'({rx_data, len_lo});
  assign last_word_c  = (32'(words_loaded) + 32'd1) == 32'(len);
  // Counter reaching TIMEOUT_CYCLES-1 on this edge aborts the load.
  assign timeout_c    = rx_state_c & ~xfer_c & (to_cnt == TO_W'(TIMEOUT_CYCLES - 2));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_ok_c;
  assign sum_ok_c = (rx_data == sum);
`endif

  imem_loader_asm u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (start_c),
    .en           (asm_en_c),
    .byte_in      (rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_n = LEN_LO;
      LEN_LO:          if (xfer_c) state_n = LEN_HI;
      LEN_HI: begin
        if (xfer_c) begin
          if (32'(len_rx_c) > MAX_WORDS) state_n = ERR;
          else if (len_rx_c == '0)       state_n = LAST_STATE;
          else                           state_n = DATA;
        end
      end
      DATA:            if (word_valid_c && last_word_c) state_n = LAST_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:             if (xfer_c) state_n = sum_ok_c ? DONE : ERR;
`endif
      default:         state_n = IDLE;
    endcase
    if (timeout_c) state_n = ERR;
  end

  // State, status flags, write port and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len_lo       <= '0;
      len          <= '0;
      to_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state    <= state_n;
      rx_ready <= rx_state_n_c;
      busy     <= rx_state_n_c;
      core_rst <= (state_n != DONE);
      done     <= (state_n == DONE);
      err      <= (state_n == ERR);
      mem_we   <= word_valid_c;

      if (word_valid_c) begin
        mem_addr     <= words_loaded[ADDR_W-1:0];
        mem_wdata    <= word_c;
        words_loaded <= words_loaded + CNT_W'(1);
      end
      if (xfer_c && state == LEN_LO) len_lo <= rx_data;
      if (xfer_c && state == LEN_HI) len    <= len_rx_c;

      if (start_c)         to_cnt <= '0;
      else if (rx_state_c) to_cnt <= xfer_c ? '0 : to_cnt + TO_W'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (start_c)       sum <= '0;
      else if (asm_en_c) sum <= sum + rx_data;
`endif
      if (start_c) words_loaded <= '0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (TIMEOUT_CYCLES=16); follows IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, core_rst, busy, done, err;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [11:0] words_loaded;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  int base = 0;

  imem_loader #(.ADDR_W(11), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Counts write strobes using the value held before each edge.
  always @(posedge clk) if (mem_we === 1'b1) we_cnt <= we_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    int n;
    n = int'($urandom_range(3, 0));
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_mem_we"},   32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"},    mem_wdata, 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
    check({tag, "_words"},    32'(words_loaded), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Two-word image at full rate
    base = we_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rx_ready", 32'(rx_ready), 32'd1);
    check("t1_core_rst", 32'(core_rst), 32'd1);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h01); send(8'h50); send(8'h00);
    check("t1_we0", 32'(mem_we), 32'd1);
    check("t1_addr0", 32'(mem_addr), 32'd0);
    check("t1_data0", mem_wdata, 32'h00500113);
    check("t1_words0", 32'(words_loaded), 32'd1);
    send(8'h93); send(8'h01); send(8'hC0); send(8'h00);
    check("t1_we1", 32'(mem_we), 32'd1);
    check("t1_addr1", 32'(mem_addr), 32'd1);
    check("t1_data1", mem_wdata, 32'h00C00193);
    check("t1_words1", 32'(words_loaded), 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t1_chk_wait", 32'(done), 32'd0);
    send(8'hB8);
`endif
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_core_run", 32'(core_rst), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_we_low", 32'(mem_we), 32'd0);
    check("t1_data_hold", mem_wdata, 32'h00C00193);
    check("t1_we_count", 32'(we_cnt - base), 32'd2);
    rx_valid = 1'b1; rx_data = 8'hFF;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("t1_no_xfer_done", 32'(done), 32'd1);
    check("t1_no_xfer_words", 32'(words_loaded), 32'd2);
    check("t1_no_xfer_we", 32'(we_cnt - base), 32'd2);

    // Zero-length image
    base = we_cnt;
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_words_clr", 32'(words_loaded), 32'd0);
    send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_chk_busy", 32'(busy), 32'd1);
    send(8'h00);
    check("t2_chk_ok", 32'(done), 32'd1);
    pulse_start();
    send(8'h00); send(8'h00); send(8'h05);
    check("t2_chk_bad", 32'(err), 32'd1);
`else
    check("t2_done", 32'(done), 32'd1);
    check("t2_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    check("t2_no_we", 32'(we_cnt - base), 32'd0);

    // Oversize length 2049
    base = we_cnt;
    pulse_start();
    check("t3_err_clr", 32'(err), 32'd0);
    send(8'h01); send(8'h08);
    check("t3_err", 32'(err), 32'd1);
    check("t3_core_rst", 32'(core_rst), 32'd1);
    check("t3_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("t3_no_we", 32'(we_cnt - base), 32'd0);

    // Inter-byte timeout
    base = we_cnt;
    pulse_start();
    send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    repeat (14) @(negedge clk);
    check("t4_err_early", 32'(err), 32'd0);
    @(negedge clk);
    check("t4_err", 32'(err), 32'd1);
    check("t4_words", 32'(words_loaded), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_we", 32'(we_cnt - base), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accept and reject
    pulse_start();
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("t5_data_ok", mem_wdata, 32'h04030201);
    send(8'h0A);
    check("t5_done", 32'(done), 32'd1);
    pulse_start();
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0B);
    check("t5_err", 32'(err), 32'd1);
    check("t5_done_low", 32'(done), 32'd0);
    check("t5_data_bad", mem_wdata, 32'h04030201);
`endif

    // Throttled stream, ignored start, reset mid-word, reload
    pulse_start();
    send_gap(8'h02); send_gap(8'h00); send_gap(8'h78); send_gap(8'h56);
    pulse_start();
    check("t6_start_ign_busy", 32'(busy), 32'd1);
    check("t6_start_ign_err", 32'(err), 32'd0);
    send_gap(8'h34); send_gap(8'h12);
    check("t6_we", 32'(mem_we), 32'd1);
    check("t6_data", mem_wdata, 32'h12345678);
    check("t6_words", 32'(words_loaded), 32'd1);
    send_gap(8'h9A); send_gap(8'hBC);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("t6_re_addr", 32'(mem_addr), 32'd0);
    check("t6_re_data", mem_wdata, 32'hDDCCBBAA);
    check("t6_re_words", 32'(words_loaded), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h0E);
`endif
    check("t6_re_done", 32'(done), 32'd1);
    check("t6_re_core", 32'(core_rst), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
